// File: rtl/mealy_fsm_1010.sv
// Serial pattern detector (Mealy): asserts out in the same cycle as the last bit of PATTERN.
// Next-state logic is a KMP transition table built at elaboration from PATTERN.
module mealy_fsm_1010 #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1010,
  parameter bit                     OVERLAP     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int SW    = $clog2(PATTERN_LEN);
  localparam int TBL_W = 2 * PATTERN_LEN * SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t S0   = '0;
  localparam state_t LAST = state_t'(PATTERN_LEN - 1);

  // Bit received at position pos of the pattern (position 0 is the MSB, received first).
  function automatic logic pat_bit(input int pos);
    return |((PATTERN >> (PATTERN_LEN - 1 - pos)) & PATTERN_LEN'(1));
  endfunction

  // Longest proper prefix of PATTERN that is a suffix of (first k pattern bits + b).
  function automatic state_t kmp_next(input int k, input logic b);
    state_t nxt;
    logic   found;
    logic   ok;
    logic   sbit;
    int     pos;
    nxt   = S0;
    found = 1'b0;
    for (int j = PATTERN_LEN - 1; j >= 1; j--) begin
      if (!found && j <= k + 1) begin
        ok = 1'b1;
        for (int m = 0; m < j; m++) begin
          pos  = k + 1 - j + m;
          sbit = (pos == k) ? b : pat_bit(pos);
          if (sbit != pat_bit(m)) ok = 1'b0;
        end
        if (ok) begin
          nxt   = state_t'(j);
          found = 1'b1;
        end
      end
    end
    return nxt;
  endfunction

  // Entry (2*k + b) holds the next state from state k on input b.
  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] tbl;
    tbl = '0;
    for (int k = 0; k < PATTERN_LEN; k++) begin
      for (int b = 0; b < 2; b++) begin
        tbl = tbl | (TBL_W'(kmp_next(k, b[0])) << ((2 * k + b) * SW));
      end
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] NXT_TBL = build_tbl();

  state_t r_state;
  state_t w_next;
  logic   w_match;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S0;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next  = S0;
    w_match = 1'b0;
    if (r_state <= LAST) begin
      w_next  = state_t'(NXT_TBL >> (int'({r_state, in}) * SW));
      w_match = (r_state == LAST) && (in == PATTERN[0]);
      if (w_match && !OVERLAP) w_next = S0;
    end
  end

  // Gated by rst so the pulse is suppressed for the whole reset interval.
  assign out = w_match & ~rst;

endmodule

// File: tb/tb_mealy_fsm_1010.sv
// Directed bench for mealy_fsm_1010: overlapping, non-overlapping and 5-bit pattern instances
// checked against hand-computed pulse positions and state values.
module tb_mealy_fsm_1010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic in5 = 1'b0;
  logic out_ov, out_no, out_p5;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mealy_fsm_1010 #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b1)) u_ov (
    .clk(clk), .rst(rst), .in(in), .out(out_ov));

  mealy_fsm_1010 #(.PATTERN_LEN(4), .PATTERN(4'b1010), .OVERLAP(1'b0)) u_no (
    .clk(clk), .rst(rst), .in(in), .out(out_no));

  mealy_fsm_1010 #(.PATTERN_LEN(5), .PATTERN(5'b11011), .OVERLAP(1'b1)) u_p5 (
    .clk(clk), .rst(rst), .in(in5), .out(out_p5));

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit between edges, then check both 1010 instances before the consuming edge.
  task automatic step(input logic b, input logic e_ov, input logic e_no, input string tag);
    @(negedge clk);
    in = b;
    #1;
    check({tag, "_ov"}, {3'b0, out_ov}, {3'b0, e_ov});
    check({tag, "_no"}, {3'b0, out_no}, {3'b0, e_no});
  endtask

  task automatic step5(input logic b, input logic e, input string tag);
    @(negedge clk);
    in5 = b;
    #1;
    check(tag, {3'b0, out_p5}, {3'b0, e});
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [11:0] stream   = 12'b1010_1010_1100;
  logic [11:0] exp_ov   = 12'b0001_0101_0000;
  logic [11:0] exp_no   = 12'b0001_0001_0000;
  logic [7:0]  stream5  = 8'b1101_1011;
  logic [7:0]  exp_p5   = 8'b0000_1001;

  initial begin
    // Test 1: reset holds out low and state at S0 while in toggles across clock edges.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in  = ~in;
      in5 = ~in5;
      #1;
      check("rst_out_ov", {3'b0, out_ov}, 4'h0);
      check("rst_out_p5", {3'b0, out_p5}, 4'h0);
    end
    check("rst_state_ov", {2'b0, u_ov.r_state}, 4'h0);
    check("rst_state_p5", {1'b0, u_p5.r_state}, 4'h0);
    @(negedge clk);
    in  = 1'b0;
    in5 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, "t1_b1");
    step(1'b0, 1'b0, 1'b0, "t1_b2");
    step(1'b1, 1'b0, 1'b0, "t1_b3");
    step(1'b0, 1'b1, 1'b1, "t1_b4");

    // Tests 2 and 3: overlapping vs non-overlapping on the same 12-bit stream.
    reset_pulse();
    for (int i = 11; i >= 0; i--) begin
      step(stream[i], exp_ov[i], exp_no[i], $sformatf("t23_bit%0d", 12 - i));
    end

    // Test 4: hold S3 and toggle in without a clock edge; out follows combinationally.
    step(1'b1, 1'b0, 1'b0, "t4_b1");
    step(1'b0, 1'b0, 1'b0, "t4_b2");
    step(1'b1, 1'b0, 1'b0, "t4_b3");
    @(negedge clk);
    in = 1'b0;
    #1 check("t4_in0_ov", {3'b0, out_ov}, 4'h1);
    in = 1'b1;
    #1 check("t4_in1_ov", {3'b0, out_ov}, 4'h0);
    check("t4_in1_no", {3'b0, out_no}, 4'h0);
    in = 1'b0;
    #1 check("t4_in0b_ov", {3'b0, out_ov}, 4'h1);
    check("t4_in0b_no", {3'b0, out_no}, 4'h1);
    @(posedge clk);
    #1;
    check("t4_state_ov", {2'b0, u_ov.r_state}, 4'h2);
    check("t4_state_no", {2'b0, u_no.r_state}, 4'h0);

    // Test 5: asynchronous reset between edges discards the partial match.
    reset_pulse();
    step(1'b1, 1'b0, 1'b0, "t5_b1");
    step(1'b0, 1'b0, 1'b0, "t5_b2");
    step(1'b1, 1'b0, 1'b0, "t5_b3");
    @(negedge clk);
    in = 1'b0;
    #1 check("t5_pre_rst_ov", {3'b0, out_ov}, 4'h1);
    rst = 1'b1;
    #1;
    check("t5_rst_out_ov", {3'b0, out_ov}, 4'h0);
    check("t5_rst_out_no", {3'b0, out_no}, 4'h0);
    check("t5_rst_state_ov", {2'b0, u_ov.r_state}, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, "t5_a0");
    step(1'b1, 1'b0, 1'b0, "t5_a1");
    step(1'b0, 1'b0, 1'b0, "t5_a2");
    step(1'b1, 1'b0, 1'b0, "t5_a3");
    step(1'b0, 1'b1, 1'b1, "t5_a4");

    // Test 6: 5-bit pattern 11011 with overlap, pulses on bits 5 and 8.
    reset_pulse();
    for (int i = 7; i >= 0; i--) begin
      step5(stream5[i], exp_p5[i], $sformatf("t6_bit%0d", 8 - i));
    end
    @(posedge clk);
    #1 check("t6_state_p5", {1'b0, u_p5.r_state}, 4'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
